uart_frame_parser: RTL and testbench

Byte-level receive framer sitting directly downstream of the UART receiver: consumes its one-cycle byte strobes and extracts framed command packets (sync, length, payload, XOR checksum). It buffers the payload in a small register file for the command decoder, and reports good frames and framing errors as single-cycle pulses. It includes an inter-byte timeout so a truncated frame cannot hang the parser.

---
 rtl/uart_frame_parser.sv | 141 ++++++++++++++
 tb/tb_uart_frame_parser.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_frame_parser.sv
// uart_frame_parser: receive-side framer behind the UART receiver.
// Extracts SYNC/LEN/payload/CHK frames from one-cycle byte strobes, buffers
// the payload for the command decoder and reports good frames and aborted
// frames as single-cycle pulses. An inter-byte timeout aborts stalled frames.
module uart_frame_parser #(
  parameter int         CLK_FREQ  = 50000000,
  parameter int         BAUD_RATE = 9600,
  parameter int         MAX_LEN   = 16,
  parameter int         TIMEOUT   = 2*10*CLK_FREQ/BAUD_RATE,
  parameter logic [7:0] SYNC      = 8'hA5
) (
  input  logic                                          clk,
  input  logic                                          rst,
  input  logic [7:0]                                    in_data,
  input  logic                                          in_valid,
  input  logic [((MAX_LEN > 1) ? $clog2(MAX_LEN) : 1)-1:0] rd_addr,
  output logic [7:0]                                    rd_data,
  output logic                                          frame_valid,
  output logic [7:0]                                    frame_len,
  output logic                                          frame_err,
  output logic [1:0]                                    err_code,
  output logic                                          busy
);

  localparam int AW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE,
    GET_LEN,
    GET_PAY,
    GET_CHK
  } state_t;

  state_t         state;
  logic [7:0]     len;
  logic [7:0]     idx;
  logic [7:0]     chk_acc;
  logic [CW-1:0]  cnt;
  logic           timeout_hit;
  logic [7:0]     pay_buf [MAX_LEN];

  // Inter-byte timeout fires only mid-frame and only when no byte arrives this cycle.
  always_comb begin
    timeout_hit = 1'b0;
    if ((state != IDLE) && !in_valid && (cnt == CW'(TIMEOUT - 1)))
      timeout_hit = 1'b1;
  end

  // Frame parser FSM: state, length/index/checksum tracking, idle counter and pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      len         <= '0;
      idx         <= '0;
      chk_acc     <= '0;
      cnt         <= '0;
      frame_valid <= 1'b0;
      frame_len   <= '0;
      frame_err   <= 1'b0;
      err_code    <= '0;
      busy        <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;

      if ((state == IDLE) || in_valid)
        cnt <= '0;
      else
        cnt <= cnt + 1'b1;

      if (timeout_hit) begin
        frame_err <= 1'b1;
        err_code  <= 2'b11;
        state     <= IDLE;
        busy      <= 1'b0;
        cnt       <= '0;
      end else if (in_valid) begin
        case (state)
          IDLE: begin
            if (in_data == SYNC) begin
              state <= GET_LEN;
              busy  <= 1'b1;
            end
          end
          GET_LEN: begin
            if ((in_data == 8'd0) || (in_data > 8'(MAX_LEN))) begin
              frame_err <= 1'b1;
              err_code  <= 2'b01;
              state     <= IDLE;
              busy      <= 1'b0;
            end else begin
              len     <= in_data;
              chk_acc <= in_data;
              idx     <= '0;
              state   <= GET_PAY;
            end
          end
          GET_PAY: begin
            chk_acc <= chk_acc ^ in_data;
            idx     <= idx + 8'd1;
            if (idx == (len - 8'd1))
              state <= GET_CHK;
          end
          GET_CHK: begin
            if (in_data == chk_acc) begin
              frame_valid <= 1'b1;
              frame_len   <= len;
            end else begin
              frame_err <= 1'b1;
              err_code  <= 2'b10;
            end
            state <= IDLE;
            busy  <= 1'b0;
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  // Payload buffer write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (in_valid && (state == GET_PAY) && !timeout_hit)
      pay_buf[idx[AW-1:0]] <= in_data;
  end

  // Registered read port; out-of-range addresses read as zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rd_data <= '0;
    else if (32'(rd_addr) < MAX_LEN)
      rd_data <= pay_buf[rd_addr];
    else
      rd_data <= '0;
  end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Self-checking bench for uart_frame_parser: table of framed byte vectors
// with a scoreboard of expected frame_valid/frame_err events, plus hand
// sequences for timeout, timeout boundary and mid-frame reset.
module tb_uart_frame_parser;

  localparam int TO = 40;
  localparam int ML = 16;
  localparam int NV = 7;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] in_data = '0;
  logic       in_valid = 1'b0;
  logic [3:0] rd_addr = '0;
  logic [7:0] rd_data;
  logic       frame_valid;
  logic [7:0] frame_len;
  logic       frame_err;
  logic [1:0] err_code;
  logic       busy;

  uart_frame_parser #(
    .MAX_LEN (ML),
    .TIMEOUT (TO),
    .SYNC    (8'hA5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data),
    .frame_valid (frame_valid),
    .frame_len   (frame_len),
    .frame_err   (frame_err),
    .err_code    (err_code),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [0:19][7:0] b;
    int               n;
    int               pstart;
    bit               is_err;
    logic [7:0]       val;
  } vec_t;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
  } exp_t;

  vec_t tv [NV];
  exp_t q [$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_iv = 0;
  int err_cyc = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Cycle counter and time of the last accepted byte strobe.
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (in_valid) last_iv = cyc;
  end

  // Scoreboard monitor: every pulse must match the next expected event.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (frame_valid || frame_err)) begin
      if (frame_valid) check("valid_err_exclusive", {31'd0, frame_err}, 32'd0);
      if (frame_err) err_cyc = cyc;
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, frame_valid, frame_err}, 32'd0);
      end else begin
        e = q.pop_front();
        if (e.is_err) begin
          check("err_pulse", {31'd0, frame_err}, 32'd1);
          check("err_code", {30'd0, err_code}, {30'd0, e.val[1:0]});
        end else begin
          check("valid_pulse", {31'd0, frame_valid}, 32'd1);
          check("frame_len", {24'd0, frame_len}, {24'd0, e.val});
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int budget);
    int n = 0;
    while (q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("event_arrived", q.size(), 32'd0);
    q.delete();
    idle(2);
  endtask

  task automatic check_rd(input logic [3:0] a, input logic [7:0] e);
    @(negedge clk);
    rd_addr = a;
    @(negedge clk);
    check($sformatf("rd_data[%0d]", a), {24'd0, rd_data}, {24'd0, e});
  endtask

  initial begin
    int k;
    logic [7:0] x;

    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] x;

    // Vector table
    tv[0].b = '0; tv[0].b[0:5] = {8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h03};
    tv[0].n = 6; tv[0].pstart = 2; tv[0].is_err = 1'b0; tv[0].val = 8'd3;
    tv[1].b = '0; tv[1].b[0:5] = {8'h5A, 8'hFF, 8'hA5, 8'h01, 8'h7E, 8'h7F};
    tv[1].n = 6; tv[1].pstart = 4; tv[1].is_err = 1'b0; tv[1].val = 8'd1;
    tv[2].b = '0; tv[2].b[0:4] = {8'hA5, 8'h02, 8'h10, 8'h20, 8'h31};
    tv[2].n = 5; tv[2].pstart = 2; tv[2].is_err = 1'b1; tv[2].val = 8'd2;
    tv[3].b = '0; tv[3].b[0:1] = {8'hA5, 8'h00};
    tv[3].n = 2; tv[3].pstart = 0; tv[3].is_err = 1'b1; tv[3].val = 8'd1;
    tv[4].b = '0; tv[4].b[0:1] = {8'hA5, 8'h11};
    tv[4].n = 2; tv[4].pstart = 0; tv[4].is_err = 1'b1; tv[4].val = 8'd1;
    tv[5].b = '0; tv[5].b[0] = 8'hA5; tv[5].b[1] = 8'h10;
    x = 8'h10;
    for (int k = 0; k < 16; k++) begin
      tv[5].b[2+k] = 8'(k * 8'h11);
      x = x ^ tv[5].b[2+k];
    end
    tv[5].b[18] = x;
    tv[5].n = 19; tv[5].pstart = 2; tv[5].is_err = 1'b0; tv[5].val = 8'd16;
    tv[6].b = '0; tv[6].b[0:4] = {8'hA5, 8'h02, 8'hA5, 8'hA5, 8'h02};
    tv[6].n = 5; tv[6].pstart = 2; tv[6].is_err = 1'b0; tv[6].val = 8'd2;

    // Reset values
    #2 rst = 1'b1;
    #1;
    check("rst_rd_data", {24'd0, rd_data}, 32'd0);
    check("rst_frame_valid", {31'd0, frame_valid}, 32'd0);
    check("rst_frame_len", {24'd0, frame_len}, 32'd0);
    check("rst_frame_err", {31'd0, frame_err}, 32'd0);
    check("rst_err_code", {30'd0, err_code}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    idle(3);
    rst = 1'b0;
    idle(2);

    // Table-driven frames, bytes back-to-back
    for (int i = 0; i < NV; i++) begin
      q.push_back('{is_err: tv[i].is_err, val: tv[i].val});
      for (int k = 0; k < tv[i].n; k++) begin
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = tv[i].b[k];
      end
      @(negedge clk);
      in_valid = 1'b0;
      wait_drain(20);
      check($sformatf("busy_after_vec%0d", i), {31'd0, busy}, 32'd0);
      if (!tv[i].is_err)
        for (int k = 0; k < int'(tv[i].val); k++)
          check_rd(4'(k), tv[i].b[tv[i].pstart + k]);
    end
    check("err_code_held", {30'd0, err_code}, 32'd1);
    check("frame_len_last", {24'd0, frame_len}, 32'd2);

    // Truncated frame: timeout exactly TO cycles after last byte
    q.push_back('{is_err: 1'b1, val: 8'd3});
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    idle(5);
    check("busy_mid_frame", {31'd0, busy}, 32'd1);
    wait_drain(TO + 20);
    check("timeout_cycles", 32'(err_cyc - last_iv), 32'(TO));
    check("busy_after_timeout", {31'd0, busy}, 32'd0);

    // Bytes arriving exactly at the timeout boundary are accepted
    q.push_back('{is_err: 1'b0, val: 8'd1});
    send_byte(8'hA5);
    idle(TO - 2);
    send_byte(8'h01);
    idle(TO - 2);
    send_byte(8'h55);
    idle(TO - 2);
    send_byte(8'h54);
    wait_drain(20);
    check_rd(4'd0, 8'h55);

    // Reset mid-frame: no error pulse, clean restart
    send_byte(8'hA5);
    send_byte(8'h03);
    send_byte(8'h11);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_frame_len", {24'd0, frame_len}, 32'd0);
    check("midrst_err_code", {30'd0, err_code}, 32'd0);
    check("midrst_rd_data", {24'd0, rd_data}, 32'd0);
    idle(2);
    rst = 1'b0;
    idle(TO + 5);
    check("postrst_busy", {31'd0, busy}, 32'd0);
    q.push_back('{is_err: 1'b0, val: 8'd1});
    send_byte(8'hA5);
    send_byte(8'h01);
    send_byte(8'h42);
    send_byte(8'h43);
    wait_drain(20);
    check_rd(4'd0, 8'h42);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
